geriyaz_yazmac_obegi: RTL



---
 rtl/geriyaz_yazmac_obegi_pkg.sv | 35 +++
 rtl/geriyaz_yazmac_obegi_yazmac_obegi.sv | 54 +++++
 rtl/geriyaz_yazmac_obegi.sv | 90 +++++++++
 3 files changed

// File: rtl/geriyaz_yazmac_obegi_pkg.sv
// ============================================================================
// Module   : geriyaz_yazmac_obegi_pkg
// Purpose  : Shared writeback-stage definitions: source-select encoding,
//            write-enable bit position inside the writeback micro-op and the
//            fixed upper bits used to rebuild link addresses from the PC.
//            The execute stage builds its writeback micro-op from the same
//            definitions.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package geriyaz_yazmac_obegi_pkg;

   // Writeback source select, micro-op bits [1:0]; 2'b11 is reserved.
   typedef enum logic [1:0] {
      GY_SEC_AMB  = 2'b00,   // ALU / divider / crypto / load result
      GY_SEC_CARP = 2'b01,   // multiplier result
      GY_SEC_PS   = 2'b10,   // link value built from the incremented PC
      GY_SEC_RSV  = 2'b11    // reserved, behaves as GY_SEC_AMB
   } gy_sec_e;

   // Position of the write-enable bit (YAZ) inside the 3-bit micro-op.
   localparam int unsigned GY_YAZ_BIT = 2;

   // Fixed upper byte of every instruction address in this core's memory map.
   localparam logic [7:0] GY_PS_UST = 8'h40;

   // Rebuild a full 32-bit link address from the halfword-granular PC field.
   function automatic logic [31:0] gy_ps_deger(input logic [18:1] ps_artmis);
      return {GY_PS_UST, 5'b0_0000, ps_artmis, 1'b0};
   endfunction

endpackage : geriyaz_yazmac_obegi_pkg

`default_nettype wire

// File: rtl/geriyaz_yazmac_obegi_yazmac_obegi.sv
// ============================================================================
// Module   : geriyaz_yazmac_obegi_yazmac_obegi
// Purpose  : 31 x 32-bit integer register array (x1..x31) with one
//            synchronous write port, two asynchronous read ports and a
//            synchronous clear. x0 is hard-wired to zero.
// Ports    : clk_i      - clock
//            rst_i      - synchronous active-high clear of x1..x31
//            i_yaz      - write enable (caller guarantees i_yaz_adres != 0)
//            i_yaz_adres/i_yaz_deger - write address / data
//            i_rs1_adres/i_rs2_adres - read addresses
//            o_rs1_deger/o_rs2_deger - read data (combinational)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module geriyaz_yazmac_obegi_yazmac_obegi
   import geriyaz_yazmac_obegi_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        i_yaz,
   input  logic [4:0]  i_yaz_adres,
   input  logic [31:0] i_yaz_deger,
   input  logic [4:0]  i_rs1_adres,
   input  logic [4:0]  i_rs2_adres,
   output logic [31:0] o_rs1_deger,
   output logic [31:0] o_rs2_deger
);

   logic [31:0] w_dizi [32];

   for (genvar i = 0; i < 32; i++) begin : g_yazmac
      if (i == 0) begin : g_x0
         // x0 has no storage at all, so it can never hold anything but zero.
         assign w_dizi[i] = 32'h0000_0000;
      end else begin : g_xn
         logic [31:0] r_deger;
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_deger <= 32'h0000_0000;
            end else if (i_yaz && (i_yaz_adres == 5'(i))) begin
               r_deger <= i_yaz_deger;
            end
         end
         assign w_dizi[i] = r_deger;
      end
   end

   assign o_rs1_deger = w_dizi[i_rs1_adres];
   assign o_rs2_deger = w_dizi[i_rs2_adres];

endmodule : geriyaz_yazmac_obegi_yazmac_obegi

`default_nettype wire

// File: rtl/geriyaz_yazmac_obegi.sv
// ============================================================================
// Module   : geriyaz_yazmac_obegi
// Purpose  : Writeback stage plus integer register file. Selects the final
//            rd value from the execute-stage bundle, commits it to the
//            register array, serves two combinational read ports and drives
//            the writeback forwarding bus.
// Config   : GY_YAZMA_ATLATMA_EN - when defined, reads of the committing rd
//            return the new value in the same cycle (write-through bypass).
//            When undefined, reads return array contents only.
// Ports    : clk_i, rst_i (synchronous, active-high)
//            yurut_rd_adres_i / yurut_ps_artmis_i / yurut_rd_deger_i /
//            yurut_carp_deger_i / yurut_mikroislem_i - execute-stage bundle
//            cyo_rs1_adres_i / cyo_rs2_adres_i      - read addresses
//            cyo_rs1_deger_o / cyo_rs2_deger_o      - read data
//            cyo_gy_yaz_o / cyo_gy_rd_adres_o / cyo_gy_deger_o - forwarding
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module geriyaz_yazmac_obegi
   import geriyaz_yazmac_obegi_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  yurut_rd_adres_i,
   input  logic [18:1] yurut_ps_artmis_i,
   input  logic [31:0] yurut_rd_deger_i,
   input  logic [31:0] yurut_carp_deger_i,
   input  logic [2:0]  yurut_mikroislem_i,
   input  logic [4:0]  cyo_rs1_adres_i,
   input  logic [4:0]  cyo_rs2_adres_i,
   output logic [31:0] cyo_rs1_deger_o,
   output logic [31:0] cyo_rs2_deger_o,
   output logic        cyo_gy_yaz_o,
   output logic [4:0]  cyo_gy_rd_adres_o,
   output logic [31:0] cyo_gy_deger_o
);

   gy_sec_e     w_sec;
   logic        w_yaz;
   logic [31:0] w_secilen;
   logic [31:0] w_rs1_dizi;
   logic [31:0] w_rs2_dizi;

   assign w_sec = gy_sec_e'(yurut_mikroislem_i[1:0]);

   // A write to x0 is dropped here, so neither the array nor the bypass ever
   // sees it.
   assign w_yaz = yurut_mikroislem_i[GY_YAZ_BIT] && (yurut_rd_adres_i != 5'd0);

   always_comb begin
      w_secilen = yurut_rd_deger_i;
      case (w_sec)
         GY_SEC_CARP: w_secilen = yurut_carp_deger_i;
         GY_SEC_PS:   w_secilen = gy_ps_deger(yurut_ps_artmis_i);
         default:     w_secilen = yurut_rd_deger_i;   // AMB and reserved
      endcase
   end

   geriyaz_yazmac_obegi_yazmac_obegi u_yazmac_obegi (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_yaz       (w_yaz),
      .i_yaz_adres (yurut_rd_adres_i),
      .i_yaz_deger (w_secilen),
      .i_rs1_adres (cyo_rs1_adres_i),
      .i_rs2_adres (cyo_rs2_adres_i),
      .o_rs1_deger (w_rs1_dizi),
      .o_rs2_deger (w_rs2_dizi)
   );

`ifdef GY_YAZMA_ATLATMA_EN
   // Write-through: a read of the register being committed this cycle sees
   // the new value, so decode needs no writeback hazard stall.
   assign cyo_rs1_deger_o = (w_yaz && (cyo_rs1_adres_i == yurut_rd_adres_i)) ?
                            w_secilen : w_rs1_dizi;
   assign cyo_rs2_deger_o = (w_yaz && (cyo_rs2_adres_i == yurut_rd_adres_i)) ?
                            w_secilen : w_rs2_dizi;
`else
   assign cyo_rs1_deger_o = w_rs1_dizi;
   assign cyo_rs2_deger_o = w_rs2_dizi;
`endif

   assign cyo_gy_yaz_o      = w_yaz;
   assign cyo_gy_rd_adres_o = yurut_rd_adres_i;
   assign cyo_gy_deger_o    = w_secilen;

endmodule : geriyaz_yazmac_obegi

`default_nettype wire
